// File: rtl/aqua_fifo_pkg.sv
// aqua_fifo_pkg: width helpers and parameter legality check shared by the FIFO slice
package aqua_fifo_pkg;

   function automatic int CLOG2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // pointers carry one extra wrap bit above the address
   function automatic int ptr_bits(input int addr_bits);
      return addr_bits + 1;
   endfunction

   // count spans 0..DEPTH, so it is as wide as a pointer
   function automatic int cnt_bits(input int addr_bits);
      return addr_bits + 1;
   endfunction

   function automatic bit levels_ok(input int addr_bits, input int af, input int ae);
      return (ae >= 0) && (ae < af) && (af >= 1) && (af <= (1 << addr_bits));
   endfunction

endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x DATA_BITS storage, one synchronous write port, one asynchronous read port
module fifo_regfile
   import aqua_fifo_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [DATA_BITS-1:0] i_wdata,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [DATA_BITS-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_BITS-1:0] r_mem [DEPTH];

   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags, overflow/underflow pulses and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_flags
   import aqua_fifo_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4,
   parameter int AF_LEVEL  = 12,
   parameter int AE_LEVEL  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 almost_empty,
   output logic                 underflow,
   output logic [ADDR_BITS:0]   count
);

   localparam int PW = ptr_bits(ADDR_BITS);
   localparam int CW = cnt_bits(ADDR_BITS);

   if (!levels_ok(ADDR_BITS, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
      $error("sync_fifo_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
   logic                 r_overflow, r_underflow;
   logic                 w_we, w_re;
   logic [DATA_BITS-1:0] w_head;

   assign empty        = r_wr_ptr == r_rd_ptr;
   assign full         = (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]) && (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]);
   assign count        = CW'(r_wr_ptr - r_rd_ptr);
   assign almost_full  = count >= CW'(AF_LEVEL);
   assign almost_empty = count <= CW'(AE_LEVEL);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;
   assign w_we         = wr_en & ~full & ~flush;
   assign w_re         = rd_en & ~empty & ~flush;

   fifo_regfile #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_regfile (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr[PW-2:0]),
      .i_wdata (wr_data),
      .i_raddr (r_rd_ptr[PW-2:0]),
      .o_rdata (w_head)
   );

   // flush wins over both requests and suppresses the error pulses
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ptr    <= flush ? '0 : r_wr_ptr + PW'(w_we);
         r_rd_ptr    <= flush ? '0 : r_rd_ptr + PW'(w_re);
         r_overflow  <= wr_en & full & ~flush;
         r_underflow <= rd_en & empty & ~flush;
      end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_data  = w_head;
   assign rd_valid = ~empty;
`else
   logic [DATA_BITS-1:0] r_rd_data;
   logic                 r_rd_valid;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_re;
         if (w_re) r_rd_data <= w_head;
      end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags at DEPTH=4, AF=3, AE=1.
// Covers the default registered-read build and, with SYNC_FIFO_FWFT_EN, the fall-through build.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
   logic [7:0] rd_data;
   logic [2:0] count;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_BITS(8), .ADDR_BITS(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .almost_empty (almost_empty),
      .underflow    (underflow),
      .count        (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({empty, almost_empty, full, almost_full, rd_valid, overflow, underflow} !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_flags got e=%b ae=%b f=%b af=%b v=%b of=%b uf=%b want 1100000",
                  empty, almost_empty, full, almost_full, rd_valid, overflow, underflow);
      end
      checks++;
      if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
`ifndef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
`endif
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         wr_data = 8'hA1 + 8'(i);
         tick();
         checks++;
         if (count !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || full !== (i == 3) || almost_empty !== (i == 0)) begin
            errors++;
            $display("FAIL fill_%0d got cnt=%0d af=%b f=%b ae=%b want cnt=%0d af=%b f=%b ae=%b",
                     i, count, almost_full, full, almost_empty, i + 1, i + 1 >= 3, i == 3, i == 0);
         end
      end
      wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      checks++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         errors++;
         $display("FAIL overflow_5th got of=%b cnt=%0d want of=1 cnt=4", overflow, count);
      end
      tick();
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle got %b want 0", overflow); end
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'hA1 + 8'(i)) begin
            errors++;
            $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'hA1 + 8'(i));
         end
         tick();
`else
         tick();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'hA1 + 8'(i)) begin
            errors++;
            $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'hA1 + 8'(i));
         end
`endif
      end
      rd_en = 1'b0;
      tick();
      checks++;
      if (empty !== 1'b1 || rd_valid !== 1'b0 || count !== 3'd0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL drained got e=%b v=%b cnt=%0d uf=%b want e=1 v=0 cnt=0 uf=0", empty, rd_valid, count, underflow);
      end
   endtask

   task automatic test_simultaneous();
      wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_data = 8'hB1 + 8'(i);
         tick();
      end
      rd_en = 1'b1;
      wr_data = 8'hB0;
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== 8'hB1) begin errors++; $display("FAIL full_rdwr_data got %h want b1", rd_data); end
      tick();
`else
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hB1) begin
         errors++;
         $display("FAIL full_rdwr_data got v=%b d=%h want v=1 d=b1", rd_valid, rd_data);
      end
`endif
      wr_en = 1'b0;
      checks++;
      if (overflow !== 1'b1 || count !== 3'd3) begin
         errors++;
         $display("FAIL full_rdwr_overflow got of=%b cnt=%0d want of=1 cnt=3", overflow, count);
      end
      for (int i = 0; i < 3; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         checks++;
         if (rd_data !== 8'hB2 + 8'(i)) begin
            errors++;
            $display("FAIL after_drop_%0d got %h want %h", i, rd_data, 8'hB2 + 8'(i));
         end
         tick();
`else
         tick();
         checks++;
         if (rd_data !== 8'hB2 + 8'(i)) begin
            errors++;
            $display("FAIL after_drop_%0d got %h want %h", i, rd_data, 8'hB2 + 8'(i));
         end
`endif
      end
      wr_en = 1'b1;
      wr_data = 8'hC0;
      tick();
      wr_en = 1'b0;
      checks++;
      if (underflow !== 1'b1 || count !== 3'd1) begin
         errors++;
         $display("FAIL empty_rdwr got uf=%b cnt=%0d want uf=1 cnt=1", underflow, count);
      end
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== 8'hC0 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_c0 got v=%b d=%h want v=1 d=c0", rd_valid, rd_data);
      end
      tick();
`else
      tick();
      checks++;
      if (rd_data !== 8'hC0 || rd_valid !== 1'b1 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL read_c0 got v=%b d=%h uf=%b want v=1 d=c0 uf=0", rd_valid, rd_data, underflow);
      end
`endif
      rd_en = 1'b0;
      tick();
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL simul_end_empty got %b want 1", empty); end
   endtask

   task automatic test_back_to_back();
      int bad_cnt = 0;
      int bad_dat = 0;
      wr_en = 1'b1;
      wr_data = 8'h00;
      tick();
      wr_data = 8'h01;
      tick();
      rd_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_data = 8'(i + 2);
`ifdef SYNC_FIFO_FWFT_EN
         if (rd_data !== 8'(i)) bad_dat++;
         tick();
`else
         tick();
         if (rd_data !== 8'(i) || rd_valid !== 1'b1) bad_dat++;
`endif
         if (count !== 3'd2) bad_cnt++;
      end
      wr_en = 1'b0;
      checks++;
      if (bad_cnt != 0) begin errors++; $display("FAIL steady_count got %0d bad cycles want 0", bad_cnt); end
      checks++;
      if (bad_dat != 0) begin errors++; $display("FAIL steady_order got %0d bad words want 0", bad_dat); end
      for (int i = 0; i < 2; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         checks++;
         if (rd_data !== 8'(20 + i)) begin errors++; $display("FAIL steady_tail_%0d got %h want %h", i, rd_data, 8'(20 + i)); end
         tick();
`else
         tick();
         checks++;
         if (rd_data !== 8'(20 + i)) begin errors++; $display("FAIL steady_tail_%0d got %h want %h", i, rd_data, 8'(20 + i)); end
`endif
      end
      rd_en = 1'b0;
      tick();
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL steady_end got e=%b cnt=%0d want e=1 cnt=0", empty, count);
      end
   endtask

   task automatic test_flush();
      wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'hD1 + 8'(i);
         tick();
      end
      checks++;
      if (count !== 3'd3) begin errors++; $display("FAIL pre_flush_count got %0d want 3", count); end
      flush = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'hEE;
      tick();
      flush = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b0;
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush got cnt=%0d e=%b of=%b uf=%b v=%b want cnt=0 e=1 of=0 uf=0 v=0",
                  count, empty, overflow, underflow, rd_valid);
      end
      wr_en = 1'b1;
      wr_data = 8'h77;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== 8'h77) begin errors++; $display("FAIL post_flush_read got %h want 77", rd_data); end
      tick();
`else
      tick();
      checks++;
      if (rd_data !== 8'h77) begin errors++; $display("FAIL post_flush_read got %h want 77", rd_data); end
`endif
      rd_en = 1'b0;
      tick();
   endtask

`ifdef SYNC_FIFO_FWFT_EN
   task automatic test_fwft();
      wr_en = 1'b1;
      wr_data = 8'h5A;
      tick();
      wr_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
         errors++;
         $display("FAIL fwft_fall got v=%b d=%h want v=1 d=5a", rd_valid, rd_data);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (empty !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL fwft_pop got e=%b v=%b want e=1 v=0", empty, rd_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_simultaneous();
      test_back_to_back();
      test_flush();
`ifdef SYNC_FIFO_FWFT_EN
      test_fwft();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
